// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined RV32I control slice: opcodes, ALUOp codes
// and the control bundle that travels down the stage registers.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection (load-use, and RAW when forwarding is off)
// plus EX operand forwarding selects.
module hazard_fwd_unit #(
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic            i_flush,
  input  logic            i_use_rs1,
  input  logic            i_use_rs2,
  input  logic [RA_W-1:0] i_id_rs1,
  input  logic [RA_W-1:0] i_id_rs2,
  input  logic            i_ex_memread,
  input  logic            i_ex_regwrite,
  input  logic [RA_W-1:0] i_ex_rs1,
  input  logic [RA_W-1:0] i_ex_rs2,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic            i_mem_regwrite,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic            i_wb_regwrite,
  input  logic [RA_W-1:0] i_wb_rd,
  output logic            o_stall,
  output logic [1:0]      o_fwd_a,
  output logic [1:0]      o_fwd_b
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_load_use;
  logic w_raw;

  assign w_ex_hit  = (i_ex_rd != '0) &&
                     ((i_use_rs1 && (i_ex_rd == i_id_rs1)) ||
                      (i_use_rs2 && (i_ex_rd == i_id_rs2)));
  assign w_mem_hit = (i_mem_rd != '0) &&
                     ((i_use_rs1 && (i_mem_rd == i_id_rs1)) ||
                      (i_use_rs2 && (i_mem_rd == i_id_rs2)));

  assign w_load_use = i_ex_memread && w_ex_hit;
  assign w_raw      = (FWD_EN == 0) &&
                      ((i_ex_regwrite && w_ex_hit) || (i_mem_regwrite && w_mem_hit));

  // A flushed ID instruction is on the wrong path, so it never holds the PC.
  assign o_stall = !i_flush && (w_load_use || w_raw);

  always_comb begin
    o_fwd_a = 2'b00;
    o_fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs1))
        o_fwd_a = 2'b10;
      else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs1))
        o_fwd_a = 2'b01;
      if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs2))
        o_fwd_b = 2'b10;
      else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs2))
        o_fwd_b = 2'b01;
    end
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control: decodes the opcode in ID and carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, with stall/bubble and forwarding selects.
module pipe_control
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int RA_W    = 5,
  parameter int FWD_EN  = 1,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic [RA_W-1:0]    rs1_i,
  input  logic [RA_W-1:0]    rs2_i,
  input  logic [RA_W-1:0]    rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               illegal_o,
  output logic [ALUOP_W-1:0] ex_ALUOp_o,
  output logic               ex_ALUSrc_o,
  output logic               ex_Branch_o,
  output logic               mem_MemWrite_o,
  output logic               mem_MemRead_o,
  output logic               wb_RegWrite_o,
  output logic               wb_MemtoReg_o,
  output logic [RA_W-1:0]    wb_rd_o,
  output logic [1:0]         fwdA_o,
  output logic [1:0]         fwdB_o
);

  ctrl_t           w_dec;
  logic            w_illegal;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_stall;
  logic            w_bubble;

  ctrl_t           r_ex_ctrl;
  logic [RA_W-1:0] r_ex_rs1;
  logic [RA_W-1:0] r_ex_rs2;
  logic [RA_W-1:0] r_ex_rd;

  logic            r_mem_memread;
  logic            r_mem_memwrite;
  logic            r_mem_memtoreg;
  logic            r_mem_regwrite;
  logic [RA_W-1:0] r_mem_rd;

  logic            r_wb_regwrite;
  logic            r_wb_memtoreg;
  logic [RA_W-1:0] r_wb_rd;

  // Unknown opcodes fall to the default arm, so they can never raise an enable.
  always_comb begin
    w_dec     = CTRL_BUBBLE;
    w_illegal = 1'b0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    case (Op_i)
      OP_R:      begin w_dec = '{1'b0, 1'b0, 1'b0, ALU_R,   1'b0, 1'b0, 1'b1}; w_use_rs2 = 1'b1; end
      OP_I:      begin w_dec = '{1'b0, 1'b0, 1'b0, ALU_I,   1'b0, 1'b1, 1'b1}; end
      OP_LOAD:   begin w_dec = '{1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b1}; end
      OP_STORE:  begin w_dec = '{1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b0}; w_use_rs2 = 1'b1; end
      OP_BRANCH: begin w_dec = '{1'b1, 1'b0, 1'b0, ALU_BR,  1'b0, 1'b0, 1'b0}; w_use_rs2 = 1'b1; end
      default:   begin w_illegal = 1'b1; w_use_rs1 = 1'b0; end
    endcase
    if (rd_i == '0)
      w_dec.regwrite = 1'b0;
  end

  hazard_fwd_unit #(
    .RA_W   (RA_W),
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .i_flush        (flush_i),
    .i_use_rs1      (w_use_rs1),
    .i_use_rs2      (w_use_rs2),
    .i_id_rs1       (rs1_i),
    .i_id_rs2       (rs2_i),
    .i_ex_memread   (r_ex_ctrl.memread),
    .i_ex_regwrite  (r_ex_ctrl.regwrite),
    .i_ex_rs1       (r_ex_rs1),
    .i_ex_rs2       (r_ex_rs2),
    .i_ex_rd        (r_ex_rd),
    .i_mem_regwrite (r_mem_regwrite),
    .i_mem_rd       (r_mem_rd),
    .i_wb_regwrite  (r_wb_regwrite),
    .i_wb_rd        (r_wb_rd),
    .o_stall        (w_stall),
    .o_fwd_a        (fwdA_o),
    .o_fwd_b        (fwdB_o)
  );

  assign w_bubble = flush_i || w_stall;

  always_ff @(posedge clk_i) begin
    if (!rst_i || w_bubble) begin
      r_ex_ctrl <= CTRL_BUBBLE;
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_rd   <= '0;
    end else begin
      r_ex_ctrl <= w_dec;
      r_ex_rs1  <= rs1_i;
      r_ex_rs2  <= rs2_i;
      r_ex_rd   <= rd_i;
    end
  end

  // EX/MEM and MEM/WB always advance; only ID/EX is replaced by a bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_rd       <= '0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_rd        <= '0;
    end else begin
      r_mem_memread  <= r_ex_ctrl.memread;
      r_mem_memwrite <= r_ex_ctrl.memwrite;
      r_mem_memtoreg <= r_ex_ctrl.memtoreg;
      r_mem_regwrite <= r_ex_ctrl.regwrite;
      r_mem_rd       <= r_ex_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_rd        <= r_mem_rd;
    end
  end

  assign stall_o        = w_stall;
  assign illegal_o      = w_illegal;
  assign ex_ALUOp_o     = r_ex_ctrl.aluop;
  assign ex_ALUSrc_o    = r_ex_ctrl.alusrc;
  assign ex_Branch_o    = r_ex_ctrl.branch;
  assign mem_MemWrite_o = r_mem_memwrite;
  assign mem_MemRead_o  = r_mem_memread;
  assign wb_RegWrite_o  = r_wb_regwrite;
  assign wb_MemtoReg_o  = r_wb_memtoreg;
  assign wb_rd_o        = r_wb_rd;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: one forwarding and one non-forwarding instance share
// the same inputs and are checked every cycle against an instruction-level model.
module tb_pipe_control;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic       clk_i   = 1'b0;
  logic       rst_i   = 1'b0;
  logic       flush_i = 1'b0;
  logic [6:0] Op_i    = 7'd0;
  logic [4:0] rs1_i   = 5'd0;
  logic [4:0] rs2_i   = 5'd0;
  logic [4:0] rd_i    = 5'd0;

  // Index 1 = FWD_EN=1 instance, index 0 = FWD_EN=0 instance.
  logic [1:0]      stallO, illegalO, aluSrcO, branchO, memWriteO, memReadO, regWriteO, memtoRegO;
  logic [1:0][1:0] aluOpO, fwdAO, fwdBO;
  logic [1:0][4:0] wbRdO;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  always #5 clk_i = ~clk_i;

  pipe_control #(.OP_W(7), .RA_W(5), .FWD_EN(1), .ALUOP_W(2)) dutFwd (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .flush_i(flush_i), .stall_o(stallO[1]), .illegal_o(illegalO[1]),
    .ex_ALUOp_o(aluOpO[1]), .ex_ALUSrc_o(aluSrcO[1]), .ex_Branch_o(branchO[1]),
    .mem_MemWrite_o(memWriteO[1]), .mem_MemRead_o(memReadO[1]),
    .wb_RegWrite_o(regWriteO[1]), .wb_MemtoReg_o(memtoRegO[1]), .wb_rd_o(wbRdO[1]),
    .fwdA_o(fwdAO[1]), .fwdB_o(fwdBO[1]));

  pipe_control #(.OP_W(7), .RA_W(5), .FWD_EN(0), .ALUOP_W(2)) dutNoFwd (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .flush_i(flush_i), .stall_o(stallO[0]), .illegal_o(illegalO[0]),
    .ex_ALUOp_o(aluOpO[0]), .ex_ALUSrc_o(aluSrcO[0]), .ex_Branch_o(branchO[0]),
    .mem_MemWrite_o(memWriteO[0]), .mem_MemRead_o(memReadO[0]),
    .wb_RegWrite_o(regWriteO[0]), .wb_MemtoReg_o(memtoRegO[0]), .wb_rd_o(wbRdO[0]),
    .fwdA_o(fwdAO[0]), .fwdB_o(fwdBO[0]));

  // Model: each in-flight instruction is a record of its decoded control bits
  // [7]branch [6]memread [5]memtoreg [4:3]aluop [2]memwrite [1]alusrc [0]regwrite.
  typedef struct packed {
    logic [7:0] ctl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } slot_t;

  slot_t pipeM [2][3];

  function automatic logic [7:0] decodeTable(input logic [6:0] op, input logic [4:0] rd);
    logic [7:0] c;
    case (op)
      OP_R:    c = 8'b0_0_0_10_0_0_1;
      OP_I:    c = 8'b0_0_0_11_0_1_1;
      OP_LD:   c = 8'b0_1_1_00_0_1_1;
      OP_ST:   c = 8'b0_0_0_00_1_1_0;
      OP_BR:   c = 8'b1_0_0_01_0_0_0;
      default: c = 8'h00;
    endcase
    if (rd == 5'd0) c[0] = 1'b0;
    return c;
  endfunction

  function automatic logic isLegal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
  endfunction

  function automatic logic idReads(input logic [4:0] r);
    logic usesRs2;
    usesRs2 = (Op_i == OP_R) || (Op_i == OP_ST) || (Op_i == OP_BR);
    return (r != 5'd0) && ((isLegal(Op_i) && rs1_i == r) || (usesRs2 && rs2_i == r));
  endfunction

  function automatic logic expStall(input int m);
    logic s;
    s = pipeM[m][0].ctl[6] && idReads(pipeM[m][0].rd);
    if (m == 0)
      s = s || (pipeM[m][0].ctl[0] && idReads(pipeM[m][0].rd))
            || (pipeM[m][1].ctl[0] && idReads(pipeM[m][1].rd));
    return s && !flush_i;
  endfunction

  function automatic logic [1:0] expFwd(input int m, input logic [4:0] rs);
    if (m == 0) return 2'b00;
    if (pipeM[m][1].ctl[0] && pipeM[m][1].rd != 5'd0 && pipeM[m][1].rd == rs) return 2'b10;
    if (pipeM[m][2].ctl[0] && pipeM[m][2].rd != 5'd0 && pipeM[m][2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Advance the model: everything shifts one stage, ID enters EX unless bubbled.
  always @(posedge clk_i) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_i) begin
        pipeM[m][0] <= '0;
        pipeM[m][1] <= '0;
        pipeM[m][2] <= '0;
      end else begin
        pipeM[m][2] <= pipeM[m][1];
        pipeM[m][1] <= pipeM[m][0];
        pipeM[m][0] <= (flush_i || expStall(m)) ? slot_t'('0)
                       : slot_t'({decodeTable(Op_i, rd_i), rs1_i, rs2_i, rd_i});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Compare both instances against the model away from the active edge.
  always @(negedge clk_i) begin
    if (checkEn) begin
      for (int m = 0; m < 2; m++) begin
        checkOutput($sformatf("m%0d_stall", m),    8'(stallO[m]),    8'(expStall(m)));
        checkOutput($sformatf("m%0d_illegal", m),  8'(illegalO[m]),  8'(!isLegal(Op_i)));
        checkOutput($sformatf("m%0d_exAluOp", m),  8'(aluOpO[m]),    8'(pipeM[m][0].ctl[4:3]));
        checkOutput($sformatf("m%0d_exAluSrc", m), 8'(aluSrcO[m]),   8'(pipeM[m][0].ctl[1]));
        checkOutput($sformatf("m%0d_exBranch", m), 8'(branchO[m]),   8'(pipeM[m][0].ctl[7]));
        checkOutput($sformatf("m%0d_memWrite", m), 8'(memWriteO[m]), 8'(pipeM[m][1].ctl[2]));
        checkOutput($sformatf("m%0d_memRead", m),  8'(memReadO[m]),  8'(pipeM[m][1].ctl[6]));
        checkOutput($sformatf("m%0d_wbRegWr", m),  8'(regWriteO[m]), 8'(pipeM[m][2].ctl[0]));
        checkOutput($sformatf("m%0d_wbMem2Reg", m),8'(memtoRegO[m]), 8'(pipeM[m][2].ctl[5]));
        checkOutput($sformatf("m%0d_wbRd", m),     8'(wbRdO[m]),     8'(pipeM[m][2].rd));
        checkOutput($sformatf("m%0d_fwdA", m),     8'(fwdAO[m]),     8'(expFwd(m, pipeM[m][0].rs1)));
        checkOutput($sformatf("m%0d_fwdB", m),     8'(fwdBO[m]),     8'(expFwd(m, pipeM[m][0].rs2)));
      end
    end
  end

  // Present one ID instruction for one cycle; returns at that cycle's negedge.
  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic fl, input logic rst);
    @(posedge clk_i);
    #1;
    Op_i = op; rs1_i = s1; rs2_i = s2; rd_i = d; flush_i = fl; rst_i = rst;
    @(negedge clk_i);
  endtask

  task automatic applyFill(input int n);
    for (int k = 0; k < n; k++) applyStimulus(OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    applyStimulus(OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkEn = 1'b1;
    checkOutput("reset_exAluOp", 8'(aluOpO[1]), 8'd0);
    checkOutput("reset_wbRegWr", 8'(regWriteO[1]), 8'd0);
    checkOutput("reset_wbRd", 8'(wbRdO[1]), 8'd0);

    // R-type rd=5 flows ID -> EX -> MEM -> WB.
    applyStimulus(OP_R, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    applyFill(1);
    checkOutput("r_exAluOp", 8'(aluOpO[1]), 8'd2);
    checkOutput("r_exAluSrc", 8'(aluSrcO[1]), 8'd0);
    applyFill(2);
    checkOutput("r_wbRegWr", 8'(regWriteO[1]), 8'd1);
    checkOutput("r_wbRd", 8'(wbRdO[1]), 8'd5);

    // Load-use: one stall cycle, bubble in EX, then MEM/WB forwarding.
    applyFill(2);
    applyStimulus(OP_LD, 5'd1, 5'd0, 5'd3, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd3, 5'd0, 5'd6, 1'b0, 1'b1);
    checkOutput("lu_stall1", 8'(stallO[1]), 8'd1);
    applyStimulus(OP_R, 5'd3, 5'd0, 5'd6, 1'b0, 1'b1);
    checkOutput("lu_stall2", 8'(stallO[1]), 8'd0);
    checkOutput("lu_bubbleAluOp", 8'(aluOpO[1]), 8'd0);
    checkOutput("lu_memRead", 8'(memReadO[1]), 8'd1);
    applyFill(1);
    checkOutput("lu_fwdA", 8'(fwdAO[1]), 8'd1);

    // EX/MEM forwarding on operand B, and no forwarding from x0.
    applyFill(2);
    applyStimulus(OP_R, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd0, 5'd4, 5'd8, 1'b0, 1'b1);
    checkOutput("fw_noStall", 8'(stallO[1]), 8'd0);
    applyFill(1);
    checkOutput("fw_fwdB", 8'(fwdBO[1]), 8'd2);
    applyFill(2);
    applyStimulus(OP_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd0, 5'd0, 5'd8, 1'b0, 1'b1);
    applyFill(1);
    checkOutput("fw_x0FwdB", 8'(fwdBO[1]), 8'd0);

    // Without forwarding a RAW stalls for two cycles.
    applyFill(3);
    applyStimulus(OP_R, 5'd1, 5'd2, 5'd7, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd7, 5'd0, 5'd9, 1'b0, 1'b1);
    checkOutput("nf_stall1", 8'(stallO[0]), 8'd1);
    applyStimulus(OP_R, 5'd7, 5'd0, 5'd9, 1'b0, 1'b1);
    checkOutput("nf_stall2", 8'(stallO[0]), 8'd1);
    applyStimulus(OP_R, 5'd7, 5'd0, 5'd9, 1'b0, 1'b1);
    checkOutput("nf_stall3", 8'(stallO[0]), 8'd0);
    applyFill(1);
    checkOutput("nf_fwdA", 8'(fwdAO[0]), 8'd0);

    // Illegal opcode decodes to a bubble.
    applyStimulus(7'h7F, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    checkOutput("il_illegal", 8'(illegalO[1]), 8'd1);
    applyFill(1);
    checkOutput("il_exAluOp", 8'(aluOpO[1]), 8'd0);
    checkOutput("il_exAluSrc", 8'(aluSrcO[1]), 8'd0);
    applyFill(1);
    checkOutput("il_memWrite", 8'(memWriteO[1]), 8'd0);
    applyFill(1);
    checkOutput("il_wbRegWr", 8'(regWriteO[1]), 8'd0);

    // Flush beats a load-use stall.
    applyFill(2);
    applyStimulus(OP_LD, 5'd1, 5'd0, 5'd3, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd3, 5'd0, 5'd6, 1'b1, 1'b1);
    checkOutput("fl_stall", 8'(stallO[1]), 8'd0);
    checkOutput("fl_stallNf", 8'(stallO[0]), 8'd0);
    applyFill(1);
    checkOutput("fl_exAluOp", 8'(aluOpO[1]), 8'd0);
    checkOutput("fl_memRead", 8'(memReadO[1]), 8'd1);

    // Reset in the middle of a stall clears everything.
    applyStimulus(OP_R, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    applyStimulus(OP_LD, 5'd1, 5'd0, 5'd6, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd6, 5'd0, 5'd7, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd6, 5'd0, 5'd7, 1'b0, 1'b0);
    applyFill(1);
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("rs%0d_exAluOp", m), 8'(aluOpO[m]), 8'd0);
      checkOutput($sformatf("rs%0d_memRead", m), 8'(memReadO[m]), 8'd0);
      checkOutput($sformatf("rs%0d_wbRegWr", m), 8'(regWriteO[m]), 8'd0);
      checkOutput($sformatf("rs%0d_wbRd", m), 8'(wbRdO[m]), 8'd0);
    end

    // Randomized traffic with a small register range to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] op;
      int sel;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2: op = OP_R;
        3, 4:    op = OP_I;
        5, 6:    op = OP_LD;
        7:       op = OP_ST;
        8:       op = OP_BR;
        default: op = 7'($urandom);
      endcase
      applyStimulus(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 63) != 0));
    end

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
